// File: rtl/hex7seg_scan.sv
// hex7seg_scan: time-multiplexed hexadecimal driver for common-segment
// 7-segment displays. Latches DIGITS nibbles plus a per-digit blank mask on
// a load strobe and scans them one digit per DIV-cycle slot. Each slot opens
// with one dead cycle to stop ghosting. Segments are active-low and digit
// enables are active-high one-hot.
//
// Build option: define HEX7SEG_LZ_BLANK_EN to darken leading zero digits.
// Digit 0 is never suppressed. Without the macro, no suppression logic
// exists and only the blank mask darkens digits.
module hex7seg_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   blank_mask,
    output logic [0:6]          seg,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    // Hex nibble to active-low pattern, bit 6 = segment a ... bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h01;
            4'h1: p = 7'h4F;
            4'h2: p = 7'h12;
            4'h3: p = 7'h06;
            4'h4: p = 7'h4C;
            4'h5: p = 7'h24;
            4'h6: p = 7'h20;
            4'h7: p = 7'h0F;
            4'h8: p = 7'h00;
            4'h9: p = 7'h04;
            4'hA: p = 7'h08;
            4'hB: p = 7'h60;
            4'hC: p = 7'h31;
            4'hD: p = 7'h42;
            4'hE: p = 7'h30;
            default: p = 7'h38;
        endcase
        return p;
    endfunction

    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                seen_wrap_q, seen_wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                frame_q, frame_d;

    logic [DIGITS-1:0]   dark_vec;
    logic [3:0]          cur_nib;
    logic                cur_dark;
    logic                cnt_wrap;
    logic                idx_last;

`ifdef HEX7SEG_LZ_BLANK_EN
    logic [DIGITS-1:0]   lz_vec;

    // Leading-zero mask: a digit is suppressed while it and every digit above it are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (shadow_val_q[4*i +: 4] == 4'h0);
            lz_vec[i]  = zero_above;
        end
    end

    assign dark_vec = shadow_blank_q | lz_vec;
`else
    assign dark_vec = shadow_blank_q;
`endif

    // Select the nibble and darkness of the digit currently being scanned.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dark = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = shadow_val_q[4*i +: 4];
                cur_dark = dark_vec[i];
            end
        end
    end

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign idx_last = (idx_q == IDX_LAST);

    // Next state: shadow capture, slot counter, digit index and frame qualifier.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        if (load) begin
            shadow_val_d   = value;
            shadow_blank_d = blank_mask;
        end
        cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        // The first frame after reset has no preceding wrap, so it gets no pulse.
        seen_wrap_d = seen_wrap_q | (cnt_wrap & idx_last);
    end

    // Output decode from the current slot: the cnt==0 cycle is dead, the rest lit unless dark.
    always_comb begin
        seg_d    = SEG_OFF;
        dig_en_d = '0;
        if ((cnt_q != '0) && !cur_dark) begin
            seg_d    = hex_to_seg(cur_nib);
            dig_en_d = DIGITS'(1) << idx_q;
        end
        frame_d = (cnt_q == '0) && (idx_q == '0) && seen_wrap_q;
    end

    // State and registered outputs; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            seen_wrap_q    <= 1'b0;
            seg_q          <= SEG_OFF;
            dig_en_q       <= '0;
            frame_q        <= 1'b0;
        end else begin
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            seen_wrap_q    <= seen_wrap_d;
            seg_q          <= seg_d;
            dig_en_q       <= dig_en_d;
            frame_q        <= frame_d;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Bench for hex7seg_scan (DIGITS=4, DIV=4). A cycle-indexed model derives the
// expected outputs from elapsed cycles since reset and the loaded data. It is
// checked every cycle, alongside directed literal expectations.
module tb_hex7seg_scan;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int W      = 4 * DIGITS;
    localparam logic [6:0] PAT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              load = 1'b0;
    logic [W-1:0]      value = '0;
    logic [DIGITS-1:0] blank_mask = '0;
    logic [0:6]        seg;
    logic [DIGITS-1:0] dig_en;
    logic              frame;

    int nvec = 0;
    int nmis = 0;
    int cur  = 0;
    logic chk_on = 1'b0;

    hex7seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .blank_mask(blank_mask), .seg(seg), .dig_en(dig_en), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, got, want);
        end
    endtask

    function automatic logic is_dark(int i, logic [W-1:0] v, logic [DIGITS-1:0] b);
        logic d;
        d = b[i];
`ifdef HEX7SEG_LZ_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == '0) d = 1'b1;
`endif
        return d;
    endfunction

    // Output n cycles after reset release: slot position n%DIV, digit (n/DIV)%DIGITS.
    function automatic logic lit_at(int n, logic [W-1:0] v, logic [DIGITS-1:0] b);
        return (n % DIV != 0) && !is_dark((n / DIV) % DIGITS, v, b);
    endfunction

    function automatic logic [6:0] seg_at(int n, logic [W-1:0] v, logic [DIGITS-1:0] b);
        int i;
        i = (n / DIV) % DIGITS;
        if (!lit_at(n, v, b)) return 7'h7F;
        return PAT[4'(v >> (4 * i))];
    endfunction

    function automatic logic [DIGITS-1:0] en_at(int n, logic [W-1:0] v, logic [DIGITS-1:0] b);
        if (!lit_at(n, v, b)) return '0;
        return DIGITS'(1) << ((n / DIV) % DIGITS);
    endfunction

    int                p = 0;
    logic [W-1:0]      m_val = '0;
    logic [DIGITS-1:0] m_blank = '0;
    logic [6:0]        e_seg = 7'h7F;
    logic [DIGITS-1:0] e_en = '0;
    logic              e_frame = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 0; m_val <= '0; m_blank <= '0;
            e_seg <= 7'h7F; e_en <= '0; e_frame <= 1'b0;
        end else begin
            e_seg   <= seg_at(p, m_val, m_blank);
            e_en    <= en_at(p, m_val, m_blank);
            e_frame <= (p > 0) && (p % (DIV * DIGITS) == 0);
            p       <= p + 1;
            if (load) begin
                m_val   <= value;
                m_blank <= blank_mask;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_dig_en", 32'(dig_en), 32'(e_en));
            chk("model_frame", 32'(frame), 32'(e_frame));
            chk("onehot_dig_en", 32'($countones(dig_en) <= 1), 32'd1);
        end
    end

    task automatic goto(input int n);
        while (cur < n) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic lit(input string nm, input logic [DIGITS-1:0] en, input logic [6:0] sg);
        chk({nm, "_en"}, 32'(dig_en), 32'(en));
        chk({nm, "_seg"}, 32'(seg), 32'(sg));
    endtask

    task automatic restart(input logic [W-1:0] v, input logic [DIGITS-1:0] b);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        lit("rst", 4'b0000, 7'h7F);
        chk("rst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; load = 1'b1; value = v; blank_mask = b;
        @(negedge clk);
        load = 1'b0;
        cur = 1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        lit("reset_state", 4'b0000, 7'h7F);
        chk("reset_frame", 32'(frame), 32'd0);
        chk_on = 1'b1;

        // Basic scan of 1A2F over two frames.
        restart(16'h1A2F, 4'b0000);
        lit("dead0", 4'b0000, 7'h7F);
        goto(2);  lit("d0_F", 4'b0001, 7'h38);
        goto(6);  lit("d1_2", 4'b0010, 7'h12);
        goto(10); lit("d2_A", 4'b0100, 7'h08);
        goto(14); lit("d3_1", 4'b1000, 7'h4F);
        goto(16); chk("no_first_frame", 32'(frame), 32'd0);
        goto(17); chk("frame_16", 32'(frame), 32'd1);
        goto(18); chk("frame_one_cycle", 32'(frame), 32'd0);
        goto(33); chk("frame_32", 32'(frame), 32'd1);

        // Every nibble value on digit 0.
        for (int v = 0; v < 16; v++) begin
            restart(W'(v), 4'b0000);
            goto(2);
            lit("nib", 4'b0001, PAT[v]);
            goto(5);
            lit("nib_dead", 4'b0000, 7'h7F);
        end

        // Per-digit blanking.
        restart(16'h1234, 4'b0101);
        goto(2);  lit("blank_d0", 4'b0000, 7'h7F);
        goto(6);  lit("blank_d1", 4'b0010, 7'h06);
        goto(10); lit("blank_d2", 4'b0000, 7'h7F);
        goto(14); lit("blank_d3", 4'b1000, 7'h4F);
        goto(17);

        // Leading zeros.
        restart(16'h00A0, 4'b0000);
        goto(2);  lit("lz_d0", 4'b0001, 7'h01);
        goto(6);  lit("lz_d1", 4'b0010, 7'h08);
`ifdef HEX7SEG_LZ_BLANK_EN
        goto(10); lit("lz_d2", 4'b0000, 7'h7F);
        goto(14); lit("lz_d3", 4'b0000, 7'h7F);
`else
        goto(10); lit("lz_d2", 4'b0100, 7'h01);
        goto(14); lit("lz_d3", 4'b1000, 7'h01);
`endif
        restart(16'h0000, 4'b0000);
        goto(2);  lit("zero_d0", 4'b0001, 7'h01);
`ifdef HEX7SEG_LZ_BLANK_EN
        goto(6);  lit("zero_d1", 4'b0000, 7'h7F);
`else
        goto(6);  lit("zero_d1", 4'b0010, 7'h01);
`endif

        // Load coinciding with a slot wrap: new digit shows new data at once.
        restart(16'h0000, 4'b0000);
        goto(3);
        load = 1'b1; value = 16'h5555; blank_mask = 4'b0000;
        goto(4);
        lit("wrap_old", 4'b0001, 7'h01);
        load = 1'b0;
        goto(5);  lit("wrap_dead", 4'b0000, 7'h7F);
        goto(6);  lit("wrap_new", 4'b0010, 7'h24);

        // Load held high, then sporadic loads; checked by the model each cycle.
        load = 1'b1;
        for (int k = 0; k < 24; k++) begin
            value = W'($urandom);
            blank_mask = DIGITS'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k < 48; k++) begin
            load = ($urandom_range(0, 3) == 0);
            value = W'($urandom);
            blank_mask = DIGITS'($urandom_range(0, 1) == 0 ? 0 : $urandom);
            @(negedge clk);
        end
        load = 1'b0;

        // Reset pulsed mid-slot on digit 2.
        restart(16'h89AB, 4'b0000);
        goto(10); lit("pre_rst_d2", 4'b0100, 7'h04);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 4'b0000, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        goto(1);  lit("post_rst_dead", 4'b0000, 7'h7F);
        goto(2);  lit("post_rst_d0", 4'b0001, 7'h01);
`ifdef HEX7SEG_LZ_BLANK_EN
        goto(6);  lit("post_rst_d1", 4'b0000, 7'h7F);
`else
        goto(6);  lit("post_rst_d1", 4'b0010, 7'h01);
`endif
        goto(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
